seq_array_div: RTL and testbench
================================

// Module: seq_array_div
// PURPOSE
//   Iterative unsigned restoring divider: the inverse of the 8x8 array multiplier.
//   Divides a 2*DW-bit dividend by a DW-bit divisor and returns a 2*DW-bit quotient and a DW-bit remainder.
//   Resolves one quotient bit per cycle (MSB first), so one shared subtractor replaces a full array.
//   Used to check multiplier products by round trip (prod / b == a, rem 0) and as the exact divide reference.
// PARAMETERS
//   DW   8   divisor/remainder width; dividend and quotient are 2*DW wide
// PORTS
//   clk           in   1     single clock, rising edge
//   rst           in   1     synchronous, active-high reset
//   in_valid      in   1     operands valid
//   in_ready      out  1     divider can accept operands (IDLE only)
//   dividend      in   2*DW  unsigned dividend
//   divisor       in   DW    unsigned divisor
//   out_valid     out  1     result valid; held until accepted
//   out_ready     in   1     consumer accepts result
//   quot          out  2*DW  quotient
//   rem           out  DW    remainder
//   div_by_zero   out  1     divisor was 0 (qualified by out_valid)
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid=0; quot=0; rem=0; div_by_zero=0; internal regs=0.
//   Reset has priority in any state: an in-flight division is discarded and no result is produced.
//   FSM states IDLE, CALC, DONE.
//   IDLE: in_ready=1. On in_valid (accept edge): latch dividend into shift reg, divisor into D;
//     clear partial remainder R (DW+1 bits); cnt=2*DW-1.
//     divisor==0 -> DONE directly: quot={2*DW{1'b1}}, rem=dividend[DW-1:0], div_by_zero=1.
//     Otherwise -> CALC.
//   CALC: in_ready=0. Each cycle: T={R[DW-1:0], dvd_msb}; shift dividend left;
//     if T>=D then R=T-D and shift in q bit 1, else R=T and shift in q bit 0.
//     When cnt==0 -> DONE; else cnt decrements.
//     The comparison uses the borrow of the (DW+1)-bit subtract; there is no separate comparator.
//   DONE: out_valid=1; quot, rem and div_by_zero are stable and unchanged while out_valid=1.
//     out_valid && out_ready -> IDLE in the same edge; out_valid drops in the next cycle.
//     The quot/rem registers keep their last values in IDLE.
//   Latency: accept edge at cycle 0; out_valid is high from cycle 2*DW+1 (17 for DW=8).
//     Divide by zero: out_valid is high from cycle 1.
//   Throughput: one division per 2*DW+2 cycles when out_ready is tied high.
//   New operands are accepted only in IDLE, so they are never accepted in the same cycle
//     that a result is handed off.
//   Width rule: remainder < divisor always, so R fits in DW bits at every step end.
//     The extra bit exists only for T.
//   The quotient never overflows, because it is 2*DW wide (e.g. 65535/1 = 65535).
//   in_valid while busy is ignored: no latch, no error flag. The source must hold the request.
// STRUCTURE
//   Shared package div_pkg: state enum {IDLE,CALC,DONE} as a 2-bit typedef; DW default;
//     DBZ_QUOT constant (all ones).
//   Sub-module div_step (combinational): inputs R, next dividend bit, D;
//     outputs new R and q bit. It is one subtract-and-select row of the array.
//   The top level holds the FSM, counter, dividend/quotient shift register, R and D registers.
// TESTING
//   1. 30000 / 100 -> quot=300, rem=0, dbz=0; out_valid first high 17 cycles after accept.
//   2. 65025 / 255 -> quot=255, rem=0; 65535 / 1 -> quot=65535, rem=0 (max quotient).
//   3. 1000 / 7 -> quot=142, rem=6; 5 / 9 -> quot=0, rem=5; 0 / 74 -> quot=0, rem=0.
//   4. 1234 / 0 -> out_valid 1 cycle after accept, dbz=1, quot=16'hFFFF, rem=8'hD2.
//   5. Backpressure: out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready=0.
//      Then out_ready=1 -> in_ready=1 next cycle; a second op 9432/131 -> quot=72, rem=0.
//   6. Reset: assert rst at CALC cycle 5 -> next cycle IDLE, out_valid=0, quot=0, rem=0.
//      A following 255*255=65025 / 255 -> quot=255.
//   Random: 10k ops against a golden a/b, a%b model; round trip with the array multiplier
//     (prod/b == a when b != 0).

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough for any practical DW; the top slices off 2*DW bits.
  localparam logic [63:0] DBZ_QUOT = '1;

endpackage

// File: rtl/seq_array_div_if.sv
// Operand/result handshake bundle between a divider and its user.
interface seq_array_div_if #(
  parameter int DW = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2*DW-1:0]   dividend;
  logic [DW-1:0]     divisor;
  logic              out_valid;
  logic              out_ready;
  logic [2*DW-1:0]   quot;
  logic [DW-1:0]     rem;
  logic              div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quot, rem, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quot, rem, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One subtract-and-select row of a restoring divider: resolves a single quotient bit.
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] r,
  input  logic          bit_in,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] r_next,
  output logic          q
);
  // T = {r, bit_in}. Its top bit is r[DW-1]; when set, T >= D regardless of the low
  // subtract, otherwise the borrow of the low subtract decides.
  logic [DW-1:0] t_low;
  logic [DW:0]   diff;

  assign t_low  = {r[DW-2:0], bit_in};
  assign diff   = {1'b0, t_low} - {1'b0, d};
  assign q      = r[DW-1] | ~diff[DW];
  assign r_next = q ? diff[DW-1:0] : t_low;
endmodule

// File: rtl/seq_array_div.sv
// Iterative unsigned restoring divider: 2*DW-bit dividend / DW-bit divisor, one quotient bit per cycle.
module seq_array_div
  import div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  seq_array_div_if.slave bus
);
  localparam int CW = $clog2(2*DW);
  localparam logic [CW-1:0] CNT_START = CW'(2*DW-1);

  state_t          state_reg, state_next;
  logic [2*DW-1:0] dvd_reg;
  logic [DW-1:0]   d_reg;
  logic [DW-1:0]   r_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2*DW-1:0] quot_reg;
  logic [DW-1:0]   rem_reg;
  logic            dbz_reg;

  logic [DW-1:0]   step_r;
  logic            step_q;
  logic            divisor_zero;

  div_step #(.DW(DW)) u_step (
    .r      (r_reg),
    .bit_in (dvd_reg[2*DW-1]),
    .d      (d_reg),
    .r_next (step_r),
    .q      (step_q)
  );

  assign divisor_zero = (bus.divisor == '0);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.in_valid) state_next = divisor_zero ? DONE : CALC;
      CALC: if (cnt_reg == '0) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The dividend register doubles as the quotient shift register: each step
  // shifts out a dividend bit at the top and shifts in a quotient bit at the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_reg  <= '0;
      d_reg    <= '0;
      r_reg    <= '0;
      cnt_reg  <= '0;
      quot_reg <= '0;
      rem_reg  <= '0;
      dbz_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            dvd_reg <= bus.dividend;
            d_reg   <= bus.divisor;
            r_reg   <= '0;
            cnt_reg <= CNT_START;
            if (divisor_zero) begin
              quot_reg <= DBZ_QUOT[2*DW-1:0];
              rem_reg  <= bus.dividend[DW-1:0];
              dbz_reg  <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd_reg <= {dvd_reg[2*DW-2:0], step_q};
          r_reg   <= step_r;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            quot_reg <= {dvd_reg[2*DW-2:0], step_q};
            rem_reg  <= step_r;
            dbz_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.out_valid   = (state_reg == DONE);
  assign bus.quot        = quot_reg;
  assign bus.rem         = rem_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_array_div.sv
// Directed and random checks of seq_array_div against a golden divide model with a result scoreboard.
module tb_seq_array_div;
  localparam int DW = 8;
  localparam int TIMEOUT = 40;

  typedef struct packed {
    logic [2*DW-1:0] quot;
    logic [DW-1:0]   rem;
    logic            dbz;
  } result_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  result_t exp_q[$];

  always #5 clk = ~clk;

  seq_array_div_if #(.DW(DW)) bus ();

  seq_array_div #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic start_op(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
    result_t r;
    if (b == 0) begin
      r.quot = 16'hFFFF;
      r.rem  = a[DW-1:0];
      r.dbz  = 1'b1;
    end else begin
      r.quot = a / b;
      r.rem  = DW'(a % b);
      r.dbz  = 1'b0;
    end
    exp_q.push_back(r);
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Returns the latency in edges from the accept edge to the first edge that sees out_valid.
  task automatic wait_valid(output int lat);
    int k = 0;
    while (!bus.out_valid && k < TIMEOUT) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    lat = k + 1;
  endtask

  task automatic finish_op(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
    result_t r;
    r = exp_q.pop_front();
    $display("op %0d / %0d -> quot=%0d rem=%0d dbz=%0b (exp %0d %0d %0b)",
             a, b, bus.quot, bus.rem, bus.div_by_zero, r.quot, r.rem, r.dbz);
    check("quot", 32'(bus.quot), 32'(r.quot));
    check("rem", 32'(bus.rem), 32'(r.rem));
    check("div_by_zero", 32'(bus.div_by_zero), 32'(r.dbz));
    @(posedge clk);
    #1;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_after_handoff", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [2*DW-1:0] a, input logic [DW-1:0] b, input int exp_lat);
    int lat;
    start_op(a, b);
    wait_valid(lat);
    if (exp_lat > 0) check("latency", 32'(lat), 32'(exp_lat));
    finish_op(a, b);
  endtask

  initial begin
    int lat;
    logic [DW-1:0] ma, mb;
    logic [2*DW-1:0] ra;
    logic [DW-1:0] rb;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_quot", 32'(bus.quot), 32'd0);
    check("reset_rem", 32'(bus.rem), 32'd0);
    check("reset_dbz", 32'(bus.div_by_zero), 32'd0);

    run_op(16'd30000, 8'd100, 17);
    run_op(16'd65025, 8'd255, 17);
    run_op(16'd65535, 8'd1, 17);
    run_op(16'd1000, 8'd7, 0);
    run_op(16'd5, 8'd9, 0);
    run_op(16'd0, 8'd74, 0);
    run_op(16'd1234, 8'd0, 1);
    check("dbz_quot_const", 32'(bus.quot), 32'h0000_FFFF);
    check("dbz_rem_const", 32'(bus.rem), 32'h0000_00D2);

    // Backpressure: result must sit unchanged while the consumer stalls.
    bus.out_ready = 1'b0;
    start_op(16'd50000, 8'd123);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_quot_stable", 32'(bus.quot), 32'd406);
      check("bp_rem_stable", 32'(bus.rem), 32'd62);
    end
    bus.out_ready = 1'b1;
    finish_op(16'd50000, 8'd123);
    run_op(16'd9432, 8'd131, 17);
    check("second_op_quot_const", 32'(bus.quot), 32'd72);

    // Reset mid-calculation discards the division.
    start_op(16'd30000, 8'd100);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    $display("reset during CALC: in_ready=%0b out_valid=%0b quot=%0d rem=%0d",
             bus.in_ready, bus.out_valid, bus.quot, bus.rem);
    check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset_quot", 32'(bus.quot), 32'd0);
    check("midreset_rem", 32'(bus.rem), 32'd0);
    run_op(16'(255 * 255), 8'd255, 17);

    // Round trip with the multiplier: (a*b)/b must give back a with no remainder.
    for (int i = 0; i < 60; i++) begin
      ma = DW'($urandom_range(0, 255));
      mb = DW'($urandom_range(1, 255));
      run_op(16'(ma) * 16'(mb), mb, 17);
      check("roundtrip_quot", 32'(bus.quot), 32'(ma));
      check("roundtrip_rem", 32'(bus.rem), 32'd0);
    end

    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = (i % 25 == 0) ? 8'd0 : DW'($urandom_range(0, 255));
      run_op(ra, rb, 0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
